// File: rtl/shift_mix_stage.sv
// AES-128 round stage after SubBytes: ShiftRows then MixColumns, with per-beat round
// tracking so the final round skips MixColumns. One or two register stages.
module shift_mix_stage #(
    parameter int LATENCY    = 1,
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_in,
    input  logic         first_in,
    input  logic [127:0] data_in,
    output logic         valid_out,
    output logic [127:0] data_out,
    output logic [3:0]   round_out,
    output logic         last_out,
    output logic         seq_err
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte s(r,c) sits at [127-8*(4c+r) -: 8] (column-major).
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    logic [3:0] rc_q, rc_d;
    logic       seq_err_q, seq_err_d;
    logic [3:0] in_round;
    logic       in_last;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rc_d      = rc_q;
        seq_err_d = seq_err_q;
        in_round  = 4'd1;
        if (valid_in) begin
            if (first_in) begin
                in_round = 4'd1;
            end else if (rc_q >= 4'd1 && rc_q < LAST_ROUND) begin
                in_round = rc_q + 4'd1;
            end else begin
                // Out-of-sequence beat: flag it and treat it as round 1.
                in_round  = 4'd1;
                seq_err_d = 1'b1;
            end
            rc_d = in_round;
        end
        in_last = (in_round == LAST_ROUND);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            rc_q      <= '0;
            seq_err_q <= 1'b0;
        end else begin
            rc_q      <= rc_d;
            seq_err_q <= seq_err_d;
        end
    end

    logic         mix_valid;
    logic [127:0] mix_data;
    logic [3:0]   mix_round;
    logic         mix_last;

    generate
        if (LATENCY == 2) begin : g_lat2
            logic         sr_valid_q, sr_valid_d;
            logic [127:0] sr_data_q, sr_data_d;
            logic [3:0]   sr_round_q, sr_round_d;
            logic         sr_last_q, sr_last_d;

            always_comb begin
                sr_valid_d = valid_in;
                sr_data_d  = sr_data_q;
                sr_round_d = sr_round_q;
                sr_last_d  = 1'b0;
                if (valid_in) begin
                    sr_data_d  = shift_rows(data_in);
                    sr_round_d = in_round;
                    sr_last_d  = in_last;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sr_valid_q <= 1'b0;
                    sr_data_q  <= '0;
                    sr_round_q <= '0;
                    sr_last_q  <= 1'b0;
                end else begin
                    sr_valid_q <= sr_valid_d;
                    sr_data_q  <= sr_data_d;
                    sr_round_q <= sr_round_d;
                    sr_last_q  <= sr_last_d;
                end
            end

            assign mix_valid = sr_valid_q;
            assign mix_data  = sr_data_q;
            assign mix_round = sr_round_q;
            assign mix_last  = sr_last_q;
        end else begin : g_lat1
            assign mix_valid = valid_in;
            assign mix_data  = shift_rows(data_in);
            assign mix_round = in_round;
            assign mix_last  = in_last;
        end
    endgenerate

    logic         valid_out_q, valid_out_d;
    logic [127:0] data_out_q, data_out_d;
    logic [3:0]   round_out_q, round_out_d;
    logic         last_out_q, last_out_d;

    always_comb begin
        valid_out_d = mix_valid;
        data_out_d  = data_out_q;
        round_out_d = round_out_q;
        last_out_d  = 1'b0;
        if (mix_valid) begin
            data_out_d  = mix_last ? mix_data : mix_columns(mix_data);
            round_out_d = mix_round;
            last_out_d  = mix_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            round_out_q <= '0;
            last_out_q  <= 1'b0;
        end else begin
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            round_out_q <= round_out_d;
            last_out_q  <= last_out_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign round_out = round_out_q;
    assign last_out  = last_out_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_shift_mix_stage.sv
// Bench for shift_mix_stage: drives LATENCY=1 and LATENCY=2 instances with the same
// stimulus and compares both against a byte-matrix / GF-multiply reference model.
module tb_shift_mix_stage;

    logic         clk;
    logic         reset;
    logic         valid_in;
    logic         first_in;
    logic [127:0] data_in;

    logic         v1_out, l1_out, e1_out;
    logic [127:0] d1_out;
    logic [3:0]   r1_out;
    logic         v2_out, l2_out, e2_out;
    logic [127:0] d2_out;
    logic [3:0]   r2_out;

    int checks = 0;
    int errors = 0;

    shift_mix_stage #(.LATENCY(1), .NUM_ROUNDS(10)) u_dut1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .first_in(first_in),
        .data_in(data_in), .valid_out(v1_out), .data_out(d1_out),
        .round_out(r1_out), .last_out(l1_out), .seq_err(e1_out)
    );

    shift_mix_stage #(.LATENCY(2), .NUM_ROUNDS(10)) u_dut2 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .first_in(first_in),
        .data_in(data_in), .valid_out(v2_out), .data_out(d2_out),
        .round_out(r2_out), .last_out(l2_out), .seq_err(e2_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: textbook GF(2^8) product and matrix form of the round.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] d, input bit bypass);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] o;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = d[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = s[r][(c+r)%4];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (bypass) begin
                    acc = t[r][c];
                end else begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k-r+4)%4], t[k][c]);
                end
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    int           m_rc;
    bit           m_err;
    bit           x1_valid, x1_last, x2_valid, x2_last, p_valid, p_last;
    logic [127:0] x1_data, x2_data, p_data;
    int           x1_round, x2_round, p_round;

    task automatic model_edge(input logic r, input logic v, input logic f, input logic [127:0] d);
        bit           bv, bl;
        int           br;
        logic [127:0] bd;
        if (r) begin
            m_rc = 0; m_err = 0;
            x1_valid = 0; x1_last = 0; x1_data = '0; x1_round = 0;
            x2_valid = 0; x2_last = 0; x2_data = '0; x2_round = 0;
            p_valid = 0; p_last = 0; p_data = '0; p_round = 0;
            return;
        end
        bv = v; bl = 0; br = 0; bd = '0;
        if (v) begin
            if (f) br = 1;
            else if (m_rc >= 1 && m_rc < 10) br = m_rc + 1;
            else begin br = 1; m_err = 1; end
            m_rc = br;
            bl = (br == 10);
            bd = ref_round(d, bl);
        end
        x2_valid = p_valid;
        x2_last  = p_valid && p_last;
        if (p_valid) begin x2_data = p_data; x2_round = p_round; end
        p_valid = bv; p_last = bl; p_data = bd; p_round = br;
        x1_valid = bv;
        x1_last  = bv && bl;
        if (bv) begin x1_data = bd; x1_round = br; end
    endtask

    task automatic step(input logic r, input logic v, input logic f, input logic [127:0] d);
        reset = r; valid_in = v; first_in = f; data_in = d;
        @(posedge clk);
        model_edge(r, v, f, d);
        #1;
        check("valid_l1", 128'(v1_out), 128'(x1_valid));
        check("data_l1",  d1_out,       x1_data);
        check("round_l1", 128'(r1_out), 128'(x1_round));
        check("last_l1",  128'(l1_out), 128'(x1_last));
        check("err_l1",   128'(e1_out), 128'(m_err));
        check("valid_l2", 128'(v2_out), 128'(x2_valid));
        check("data_l2",  d2_out,       x2_data);
        check("round_l2", 128'(r2_out), 128'(x2_round));
        check("last_l2",  128'(l2_out), 128'(x2_last));
        check("err_l2",   128'(e2_out), 128'(m_err));
    endtask

    localparam logic [127:0] R1_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] R1_OUT  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] R10_IN  = 128'he9098972cb31075f3d327d94af2e2cb5;
    localparam logic [127:0] R10_OUT = 128'he9317db5cb322c723d2e895faf090794;

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        clk = 0; reset = 1; valid_in = 0; first_in = 0; data_in = '0;

        // Reset then idle.
        step(1, 0, 0, '0);
        step(1, 1, 1, rnd128());
        for (int i = 0; i < 20; i++) step(0, 0, $urandom_range(0, 1), rnd128());

        // Full ten-round block using the FIPS-197 round 1 and round 10 states.
        step(0, 1, 1, R1_IN);
        check("fips_r1_l1", d1_out, R1_OUT);
        check("fips_r1_round_l1", 128'(r1_out), 128'(1));
        for (int b = 2; b <= 9; b++) begin
            step(0, 1, 0, rnd128());
            if (b == 2) check("fips_r1_l2", d2_out, R1_OUT);
        end
        step(0, 1, 0, R10_IN);
        check("fips_r10_l1", d1_out, R10_OUT);
        check("fips_r10_last_l1", 128'(l1_out), 128'(1));
        check("fips_r10_round_l1", 128'(r1_out), 128'(10));
        step(0, 0, 0, '0);
        check("fips_r10_l2", d2_out, R10_OUT);
        check("fips_r10_last_l2", 128'(l2_out), 128'(1));
        step(0, 0, 0, '0);

        // Non-first beat straight after reset: sticky sequence error, processed as round 1.
        step(1, 0, 0, '0);
        step(0, 1, 0, R1_IN);
        check("seqerr_data_l1", d1_out, R1_OUT);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0);
        check("seqerr_sticky", 128'(e1_out), 128'(1));
        step(0, 1, 1, rnd128());
        check("seqerr_still", 128'(e2_out), 128'(1));

        // Reset mid-block after beat 5, then a fresh block.
        step(1, 0, 0, '0);
        step(0, 1, 1, rnd128());
        for (int b = 2; b <= 5; b++) step(0, 1, 0, rnd128());
        step(1, 1, 0, rnd128());
        check("midreset_v1", 128'(v1_out), 128'(0));
        check("midreset_v2", 128'(v2_out), 128'(0));
        step(0, 0, 0, '0);
        check("midreset_no_stale_l2", 128'(v2_out), 128'(0));
        step(0, 1, 1, rnd128());
        check("restart_round_l1", 128'(r1_out), 128'(1));
        step(0, 0, 0, '0);
        check("restart_round_l2", 128'(r2_out), 128'(1));

        // Randomized streaming with occasional restarts, idles and resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 11) == 0), rnd128());
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
